// File: rtl/qsys_sysid_pkg.sv
// Shared constants for the system-ID/health slave: register map, CTRL bit positions, bus width.
package qsys_sysid_pkg;

  localparam int unsigned DATA_W = 32;

  localparam logic [2:0] ADDR_ID        = 3'd0;
  localparam logic [2:0] ADDR_TIMESTAMP = 3'd1;
  localparam logic [2:0] ADDR_SCRATCH   = 3'd2;
  localparam logic [2:0] ADDR_UPTIME_LO = 3'd3;
  localparam logic [2:0] ADDR_UPTIME_HI = 3'd4;
  localparam logic [2:0] ADDR_SECONDS   = 3'd5;
  localparam logic [2:0] ADDR_CTRL      = 3'd6;
  localparam logic [2:0] ADDR_RSVD      = 3'd7;

  localparam int unsigned CTRL_CLEAR_BIT = 0;
  localparam int unsigned CTRL_WRAP_BIT  = 1;

endpackage

// File: rtl/sysid_uptime_counter.sv
// Free-running 64-bit uptime, one-second prescaler, seconds counter and sticky seconds-wrap flag.
module sysid_uptime_counter #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        clear,
  input  logic        wrap_clr,
  output logic [63:0] uptime,
  output logic [31:0] seconds,
  output logic        wrap_flag
);

  localparam int unsigned PRESC_W = $clog2(CLK_FREQ_HZ);
  localparam logic [PRESC_W-1:0] PRESC_MAX = PRESC_W'(CLK_FREQ_HZ - 1);

  logic [63:0]        uptime_q, uptime_d;
  logic [PRESC_W-1:0] presc_q, presc_d;
  logic [31:0]        seconds_q, seconds_d;
  logic               wrap_q, wrap_d;
  logic               tick;

  always_comb begin
    tick      = (presc_q == PRESC_MAX);
    uptime_d  = uptime_q + 64'd1;
    presc_d   = tick ? '0 : presc_q + PRESC_W'(1);
    seconds_d = seconds_q + 32'(tick);
    wrap_d    = wrap_q;
    if (wrap_clr) begin
      wrap_d = 1'b0;
    end
    // A wrap happening on the clear edge is still reported.
    if (tick && (seconds_q == '1)) begin
      wrap_d = 1'b1;
    end
    if (clear) begin
      uptime_d  = '0;
      presc_d   = '0;
      seconds_d = '0;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      uptime_q  <= '0;
      presc_q   <= '0;
      seconds_q <= '0;
      wrap_q    <= 1'b0;
    end else begin
      uptime_q  <= uptime_d;
      presc_q   <= presc_d;
      seconds_q <= seconds_d;
      wrap_q    <= wrap_d;
    end
  end

  assign uptime    = uptime_q;
  assign seconds   = seconds_q;
  assign wrap_flag = wrap_q;

endmodule

// File: rtl/qsys_sysid_ext.sv
// Avalon-MM system-ID/health slave: ID, build timestamp, scratch, coherent uptime, seconds, CTRL.
module qsys_sysid_ext
  import qsys_sysid_pkg::*;
#(
  parameter logic [31:0] ID          = 32'h0000_0000,
  parameter logic [31:0] TIMESTAMP   = 32'd1375083247,
  parameter int unsigned CLK_FREQ_HZ = 50_000_000
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [2:0]        address,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  input  logic [3:0]        byteenable,
  output logic [DATA_W-1:0] readdata,
  output logic              readdatavalid
);

  logic [DATA_W-1:0] scratch_q, scratch_d;
  logic [DATA_W-1:0] snap_q;
  logic [DATA_W-1:0] rdata_d;
  logic [DATA_W-1:0] ctrl_rd;
  logic [63:0]       uptime;
  logic [31:0]       seconds;
  logic              wrap_flag;
  logic              wr_ctrl, clear, wrap_clr;

  sysid_uptime_counter #(
    .CLK_FREQ_HZ(CLK_FREQ_HZ)
  ) u_cnt (
    .clock    (clock),
    .reset_n  (reset_n),
    .clear    (clear),
    .wrap_clr (wrap_clr),
    .uptime   (uptime),
    .seconds  (seconds),
    .wrap_flag(wrap_flag)
  );

  always_comb begin
    wr_ctrl   = write && (address == ADDR_CTRL);
    clear     = wr_ctrl && writedata[CTRL_CLEAR_BIT];
    wrap_clr  = wr_ctrl && writedata[CTRL_WRAP_BIT];
    scratch_d = scratch_q;
    for (int i = 0; i < 4; i++) begin
      if (write && (address == ADDR_SCRATCH) && byteenable[i]) begin
        scratch_d[8*i +: 8] = writedata[8*i +: 8];
      end
    end
  end

  // Read mux uses pre-edge register values, so a same-cycle write is not visible yet.
  always_comb begin
    ctrl_rd                = '0;
    ctrl_rd[CTRL_WRAP_BIT] = wrap_flag;
    unique case (address)
      ADDR_ID:        rdata_d = ID;
      ADDR_TIMESTAMP: rdata_d = TIMESTAMP;
      ADDR_SCRATCH:   rdata_d = scratch_q;
      ADDR_UPTIME_LO: rdata_d = uptime[31:0];
      ADDR_UPTIME_HI: rdata_d = snap_q;
      ADDR_SECONDS:   rdata_d = seconds;
      ADDR_CTRL:      rdata_d = ctrl_rd;
      ADDR_RSVD:      rdata_d = '0;
      default:        rdata_d = '0;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      scratch_q     <= '0;
      snap_q        <= '0;
      readdata      <= '0;
      readdatavalid <= 1'b0;
    end else begin
      scratch_q     <= scratch_d;
      readdatavalid <= read;
      if (read) begin
        readdata <= rdata_d;
      end
      // Latch the high word together with the low-word read so the pair is coherent.
      if (read && (address == ADDR_UPTIME_LO)) begin
        snap_q <= uptime[63:32];
      end
    end
  end

endmodule

// File: tb/tb_qsys_sysid_ext.sv
// Self-checking bench for qsys_sysid_ext: vector table for the register map plus counter sequences.
module tb_qsys_sysid_ext;

  localparam logic [31:0] TB_ID   = 32'h5EED_1D01;
  localparam logic [31:0] TB_TS   = 32'd1375083247;
  localparam int unsigned TB_FREQ = 10;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [2:0]  address = '0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [31:0] writedata = '0;
  logic [3:0]  byteenable = '0;
  logic [31:0] readdata;
  logic        readdatavalid;

  qsys_sysid_ext #(
    .ID         (TB_ID),
    .TIMESTAMP  (TB_TS),
    .CLK_FREQ_HZ(TB_FREQ)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .address      (address),
    .read         (read),
    .write        (write),
    .writedata    (writedata),
    .byteenable   (byteenable),
    .readdata     (readdata),
    .readdatavalid(readdatavalid)
  );

  always #5 clock = ~clock;

  typedef struct {
    string       name;
    logic [31:0] data;
  } exp_t;

  typedef struct {
    logic        is_wr;
    logic [2:0]  addr;
    logic [31:0] data;
    logic [3:0]  be;
    logic [31:0] exp;
  } vec_t;

  localparam int NVEC = 16;
  vec_t vecs [NVEC];

  exp_t        sb_q[$];
  int unsigned n_total = 0;
  int unsigned n_pass = 0;
  logic [31:0] last_rdata = '0;

  // Reference state for the counters and snapshot
  logic [63:0] m_uptime = '0;
  int unsigned m_presc = 0;
  logic [31:0] m_seconds = '0;
  logic [31:0] m_snap = '0;
  logic        m_wrap = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
  endtask

  task automatic model_reset();
    m_uptime  = '0;
    m_presc   = 0;
    m_seconds = '0;
    m_snap    = '0;
    m_wrap    = 1'b0;
  endtask

  function automatic logic [31:0] model_read(input logic [2:0] a);
    case (a)
      3'd3:    return m_uptime[31:0];
      3'd4:    return m_snap;
      3'd5:    return m_seconds;
      3'd6:    return {30'd0, m_wrap, 1'b0};
      default: return 32'd0;
    endcase
  endfunction

  task automatic model_step();
    logic term;
    logic ctrl_wr;
    ctrl_wr = write && (address == 3'd6);
    if (read && (address == 3'd3)) m_snap = m_uptime[63:32];
    term = (m_presc == TB_FREQ - 1);
    if (term && (m_seconds == 32'hFFFF_FFFF)) m_wrap = 1'b1;
    else if (ctrl_wr && writedata[1]) m_wrap = 1'b0;
    if (ctrl_wr && writedata[0]) begin
      m_uptime  = '0;
      m_presc   = 0;
      m_seconds = '0;
    end else begin
      m_uptime  = m_uptime + 64'd1;
      m_presc   = term ? 0 : m_presc + 1;
      m_seconds = m_seconds + 32'(term);
    end
  endtask

  // One clock: sample at the edge, compare 1 time unit later, return at the next falling edge.
  task automatic cycle();
    logic ev;
    exp_t e;
    @(posedge clock);
    ev = read && reset_n;
    model_step();
    #1;
    if (ev || readdatavalid) begin
      check("rdvalid_latency", {31'd0, readdatavalid}, {31'd0, ev});
    end
    if (ev) begin
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL scoreboard_underflow: got a read, want a queued expectation");
      end else begin
        e = sb_q.pop_front();
        check(e.name, readdata, e.data);
        last_rdata = e.data;
      end
    end
    @(negedge clock);
    read  = 1'b0;
    write = 1'b0;
  endtask

  task automatic rd(input logic [2:0] a, input string name, input logic [31:0] exp);
    exp_t e;
    e.name  = name;
    e.data  = exp;
    sb_q.push_back(e);
    address = a;
    read    = 1'b1;
    cycle();
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] be);
    address    = a;
    writedata  = d;
    byteenable = be;
    write      = 1'b1;
    cycle();
  endtask

  task automatic idle(input int n);
    repeat (n) cycle();
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    read    = 1'b0;
    write   = 1'b0;
    sb_q.delete();
    model_reset();
    @(negedge clock);
    @(negedge clock);
    reset_n = 1'b1;
  endtask

  initial begin
    vecs[0]  = '{1'b0, 3'd0, 32'h0, 4'h0, TB_ID};
    vecs[1]  = '{1'b0, 3'd1, 32'h0, 4'h0, TB_TS};
    vecs[2]  = '{1'b0, 3'd7, 32'h0, 4'h0, 32'h0};
    vecs[3]  = '{1'b0, 3'd2, 32'h0, 4'h0, 32'h0};
    vecs[4]  = '{1'b1, 3'd2, 32'hAABB_CCDD, 4'b1111, 32'h0};
    vecs[5]  = '{1'b0, 3'd2, 32'h0, 4'h0, 32'hAABB_CCDD};
    vecs[6]  = '{1'b1, 3'd2, 32'h1122_3344, 4'b0101, 32'h0};
    vecs[7]  = '{1'b0, 3'd2, 32'h0, 4'h0, 32'hAA22_CC44};
    vecs[8]  = '{1'b1, 3'd0, 32'hFFFF_FFFF, 4'b1111, 32'h0};
    vecs[9]  = '{1'b0, 3'd0, 32'h0, 4'h0, TB_ID};
    vecs[10] = '{1'b1, 3'd7, 32'h1234_5678, 4'b1111, 32'h0};
    vecs[11] = '{1'b0, 3'd7, 32'h0, 4'h0, 32'h0};
    vecs[12] = '{1'b1, 3'd2, 32'h0000_0000, 4'b1000, 32'h0};
    vecs[13] = '{1'b0, 3'd2, 32'h0, 4'h0, 32'h0022_CC44};
    vecs[14] = '{1'b1, 3'd1, 32'h0, 4'b1111, 32'h0};
    vecs[15] = '{1'b0, 3'd1, 32'h0, 4'h0, TB_TS};

    // Reset values while reset is held
    @(negedge clock);
    check("reset_readdata", readdata, 32'h0);
    check("reset_rdvalid", {31'd0, readdatavalid}, 32'h0);
    reset_n = 1'b1;

    // Reset asserted while a read response is on the bus
    wr(3'd2, 32'h1234_5678, 4'hF);
    rd(3'd2, "scratch_pre_reset", 32'h1234_5678);
    reset_n = 1'b0;
    #1;
    check("async_rst_rdvalid", {31'd0, readdatavalid}, 32'h0);
    check("async_rst_readdata", readdata, 32'h0);
    sb_q.delete();
    model_reset();
    address = 3'd2;
    read    = 1'b1;
    @(posedge clock);
    #1;
    check("read_in_reset_lost", {31'd0, readdatavalid}, 32'h0);
    @(negedge clock);
    read    = 1'b0;
    reset_n = 1'b1;
    rd(3'd2, "scratch_after_reset", 32'h0);
    rd(3'd5, "seconds_after_reset", 32'h0);
    rd(3'd4, "snap_after_reset", 32'h0);

    // Register map vectors
    for (int i = 0; i < NVEC; i++) begin
      if (vecs[i].is_wr) wr(vecs[i].addr, vecs[i].data, vecs[i].be);
      else rd(vecs[i].addr, $sformatf("vec%0d_addr%0d", i, vecs[i].addr), vecs[i].exp);
    end

    // readdata holds between reads
    idle(3);
    check("readdata_hold", readdata, last_rdata);

    // Same-cycle read and write: read returns the pre-write value
    begin
      exp_t e;
      e.name = "rw_same_cycle";
      e.data = 32'h0022_CC44;
      sb_q.push_back(e);
      address    = 3'd2;
      writedata  = 32'hDEAD_BEEF;
      byteenable = 4'hF;
      read       = 1'b1;
      write      = 1'b1;
      cycle();
    end
    rd(3'd2, "rw_after_write", 32'hDEAD_BEEF);

    // Coherent LO/HI pair across a carry into the upper word
    force dut.u_cnt.uptime_q = 64'h0000_0001_FFFF_FFFE;
    m_uptime = 64'h0000_0001_FFFF_FFFE;
    #1;
    release dut.u_cnt.uptime_q;
    rd(3'd3, "uptime_lo", 32'hFFFF_FFFE);
    idle(3);
    rd(3'd4, "uptime_hi_snap", 32'h0000_0001);
    rd(3'd4, "snap_stable", 32'h0000_0001);
    rd(3'd3, "uptime_lo_again", model_read(3'd3));
    rd(3'd4, "snap_relatched", 32'h0000_0002);

    // Seconds count and clear
    do_reset();
    idle(34);
    rd(3'd5, "seconds_35", 32'd3);
    rd(3'd3, "uptime_lo_36", 32'd35);
    wr(3'd6, 32'h1, 4'hF);
    rd(3'd3, "uptime_after_clear", 32'd0);
    rd(3'd5, "seconds_after_clear", 32'd0);
    idle(7);
    rd(3'd5, "seconds_before_tick", 32'd0);
    rd(3'd5, "seconds_tick", 32'd1);
    rd(3'd6, "ctrl_clear_selfclr", 32'd0);

    // Seconds wrap and W1C flag
    force dut.u_cnt.presc_q = 4'd9;
    force dut.u_cnt.seconds_q = 32'hFFFF_FFFF;
    m_presc   = 9;
    m_seconds = 32'hFFFF_FFFF;
    #1;
    release dut.u_cnt.presc_q;
    release dut.u_cnt.seconds_q;
    rd(3'd5, "seconds_pre_wrap", 32'hFFFF_FFFF);
    rd(3'd5, "seconds_wrapped", 32'h0);
    rd(3'd6, "ctrl_wrap_flag", 32'h2);
    wr(3'd6, 32'h2, 4'hF);
    rd(3'd6, "ctrl_w1c", 32'h0);

    // Clear and wrap on the same edge: counters clear, flag still set
    force dut.u_cnt.presc_q = 4'd9;
    force dut.u_cnt.seconds_q = 32'hFFFF_FFFF;
    m_presc   = 9;
    m_seconds = 32'hFFFF_FFFF;
    #1;
    release dut.u_cnt.presc_q;
    release dut.u_cnt.seconds_q;
    wr(3'd6, 32'h1, 4'hF);
    rd(3'd5, "clear_wins_seconds", 32'h0);
    rd(3'd6, "clear_wrap_flag_set", 32'h2);
    rd(3'd3, "clear_wins_uptime", model_read(3'd3));

    idle(2);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
